// File: rtl/buf_pkg.sv
// rtl/buf_pkg.sv - shared types and defaults for the buffer-address allocator
package buf_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_POOL_DEPTH = 1 << DEF_ADDR_W;

  typedef logic [DEF_ADDR_W-1:0] buf_addr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/buf_addr_alloc_arb_if.sv
// rtl/buf_addr_alloc_arb_if.sv - free-address push, request/grant and pool status bundle
interface buf_addr_alloc_arb_if
  import buf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W
);

  logic                free_addr_wr;
  logic [ADDR_W-1:0]   free_addr;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  gnt;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                pool_empty;
  logic [ADDR_W:0]     pool_count;
  logic                overflow_err;

  // recycle manager and port writers drive the request side
  modport master (
    output free_addr_wr, free_addr, req,
    input  gnt, gnt_addr, pool_empty, pool_count, overflow_err
  );

  // the allocator answers with grants and pool status
  modport slave (
    input  free_addr_wr, free_addr, req,
    output gnt, gnt_addr, pool_empty, pool_count, overflow_err
  );

endinterface

// File: rtl/buf_addr_alloc_arb_rr_arbiter.sv
// rtl/buf_addr_alloc_arb_rr_arbiter.sv - one-hot winner pick from req and rr_ptr (BUF_ALLOC_STRICT_PRI_EN: fixed priority)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   win
);

  logic found;
  int   idx;

`ifdef BUF_ALLOC_STRICT_PRI_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

  // scan upward from the start position with wrap; first set request wins
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef BUF_ALLOC_STRICT_PRI_EN
      idx = i;
`else
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/buf_addr_alloc_arb.sv
// rtl/buf_addr_alloc_arb.sv - free-address pool shared among requesters (BUF_ALLOC_STRICT_PRI_EN selects fixed priority)
module buf_addr_alloc_arb
  import buf_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int POOL_DEPTH = DEF_POOL_DEPTH
) (
  input logic                   clk,
  input logic                   reset,
  buf_addr_alloc_arb_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(POOL_DEPTH);

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    win_q;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_win;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [ADDR_W-1:0]   gnt_addr_q;

  // pointers wrap by natural overflow because POOL_DEPTH == 2**ADDR_W
  logic [ADDR_W-1:0]   mem [POOL_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     count_next;
  logic                empty_q;
  logic                ovf_q;
  logic                push;
  logic                pop;

  // a grant (and the matching pop) fires only from idle with work and stock
  assign pop  = (state == S_IDLE) && (count != '0) && (bus.req != '0);
  assign push = bus.free_addr_wr && (count < FULL_CNT);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .win    (arb_win)
  );

  // next occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // pool storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.free_addr;
  end

  // pool pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.free_addr_wr && !push) ovf_q <= 1'b1;
      count   <= count_next;
      empty_q <= (count_next == '0);
    end
  end

  // grant sequencer: idle -> grant (1 cycle) -> gap (1 cycle) -> idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gnt_q      <= '0;
      gnt_addr_q <= '0;
      rr_ptr     <= '0;
      win_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            gnt_q      <= arb_gnt;
            gnt_addr_q <= mem[rd_ptr];
            win_q      <= arb_win;
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          gnt_q <= '0;
`ifdef BUF_ALLOC_STRICT_PRI_EN
          rr_ptr <= '0;
`else
          rr_ptr <= (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
`endif
          state <= S_GAP;
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          gnt_q <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BUF_ALLOC_STRICT_PRI_EN
  logic unused_win_q;
  assign unused_win_q = ^win_q;
`endif

  assign bus.gnt          = gnt_q;
  assign bus.gnt_addr     = gnt_addr_q;
  assign bus.pool_count   = count;
  assign bus.pool_empty   = empty_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: doc/buf_addr_alloc_arb.md
Name: buf_addr_alloc_arb

Overview:
- Buffer-address allocator that holds the pool of free buffer addresses and shares it between NUM_REQ packet-input requesters.
- Upstream is the free-address stream (address-recycle manager output: initial 0..15 burst, then recycled addresses).
- Downstream are the input-port writers. Each requester receives exactly one free address per grant.
- Arbitration between requesters is round-robin.

Parameters:
- NUM_REQ, 4, number of requesting ports.
- ADDR_W, 4, buffer address width.
- POOL_DEPTH, 16, free-pool capacity; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- free_addr_wr  in  1  free-address write strobe from the recycle manager.
- free_addr  in  ADDR_W  free address to push into the pool.
- req  in  NUM_REQ  level request per port; held high until that port's grant.
- gnt  out  NUM_REQ  one-hot grant pulse, 1 cycle.
- gnt_addr  out  ADDR_W  allocated address; valid while gnt != 0.
- pool_empty  out  1  pool holds no free address.
- pool_count  out  ADDR_W+1  number of free addresses held, 0..POOL_DEPTH.
- overflow_err  out  1  sticky flag: a write was attempted while the pool was full.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - gnt=0, gnt_addr=0, pool_count=0, pool_empty=1, overflow_err=0.
  - Read/write pointers = 0, rr_ptr = 0, state = S_IDLE.
  - Reset asserted mid-grant drops gnt on the next edge. The address in flight is lost; upstream re-initialises the pool.
- Pool: circular buffer of POOL_DEPTH x ADDR_W.
  - Push on free_addr_wr when pool_count < POOL_DEPTH.
  - Pop only on a grant.
  - Push and pop in the same cycle: pool_count unchanged, both pointers advance.
  - Push when full: data dropped, pointers unchanged, overflow_err set until reset.
  - Pointers wrap modulo POOL_DEPTH.
- FSM, registered outputs:
  - S_IDLE: if pool_count != 0 and req != 0:
    - Select the winner W: the first requester set at or after rr_ptr, scanning upward with wrap.
    - Drive gnt[W]=1 and gnt_addr = pool[rd_ptr] on the next edge.
    - Pop the pool and go to S_GRANT.
    - If no request or the pool is empty, stay in S_IDLE with gnt=0.
  - S_GRANT: gnt held 1 cycle. Set rr_ptr = (W+1) mod NUM_REQ. Clear gnt. Go to S_GAP.
  - S_GAP: 1 cycle with gnt=0, so the granted port can deassert req. Return to S_IDLE.
- Throughput and latency:
  - Maximum throughput is 1 grant per 3 cycles.
  - Latency from req rising (pool non-empty, no contention) to gnt is 1 cycle.
- A push that arrives in the cycle the pool is empty is eligible for a grant on the following S_IDLE evaluation, not the same cycle.
- gnt_addr holds its last value when gnt=0. The checker must ignore gnt_addr at that time.
- pool_count and pool_empty are registered and reflect the post-edge occupancy.

Optional Feature:
- Macro: BUF_ALLOC_STRICT_PRI_EN.
- Defined: fixed priority, req[0] highest, rr_ptr unused (held at 0).
- Undefined: round-robin as described above.

Decomposition:
- Shared package buf_pkg:
  - ADDR_W and POOL_DEPTH defaults.
  - State encodings S_IDLE=2'd0, S_GRANT=2'd1, S_GAP=2'd2.
  - Typedef buf_addr_t (ADDR_W bits).
- Sub-module rr_arbiter: combinational one-hot winner selection from req and rr_ptr.
  - Parameter NUM_REQ.
  - Honours BUF_ALLOC_STRICT_PRI_EN.
- Pool storage and FSM stay in the top level.

Test Plan:
- Init fill: push 0..15 over 16 cycles -> pool_count=16, pool_empty=0, overflow_err=0.
- Overflow: with the pool full, push 4'h3 -> overflow_err=1 and stays 1; pool_count stays 16.
- Single port: req=4'b0001 held -> gnt=4'b0001 with gnt_addr=0 one cycle later; pool_count=15.
- Round robin: req=4'b1111 held for 12 cycles -> grant order 0,1,2,3, addresses 0,1,2,3, one grant every 3 cycles. With BUF_ALLOC_STRICT_PRI_EN defined, req=4'b1111 held -> every grant goes to port 0.
- Empty pool: pool empty and req=4'b0010 -> no gnt. Push addr 4'h9 -> gnt=4'b0010 with gnt_addr=9 two cycles after the push; pool_count returns to 0.
- Simultaneous push/pop and reset: with pool_count=5, a push coincides with a grant -> pool_count stays 5. Assert reset during S_GRANT -> next cycle gnt=0, pool_count=0, state S_IDLE.
